// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo_sync_flags FIFO.
// - fifo_depth():     number of entries for a given pointer width
// - fifo_cnt_width(): width of an occupancy counter able to hold 0..depth
// - fifo_status_t:    grouped registered status flags
package fifo_pkg;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // One extra bit so the counter can represent a completely full FIFO.
    function automatic int unsigned fifo_cnt_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

    localparam int unsigned DefaultAddrWidth = 2;
    localparam int unsigned DefaultCntWidth  = fifo_cnt_width(DefaultAddrWidth);

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_sync_flags: DEPTH x DATA_WIDTH registers with one
// synchronous write port and one combinational (show-ahead) read port.
// Ports:
//   clk_i    write clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
// The array has no reset: contents are don't-care until written.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous single-clock show-ahead FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and synchronous flush.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr, rd, flush         write, pop and synchronous clear requests
//   w_data                write data
//   af_thresh, ae_thresh  almost-full / almost-empty thresholds (0..2*DEPTH-1)
//   r_data                head word, valid while empty is low
//   full, empty           count == DEPTH / count == 0
//   almost_full           count >= af_thresh
//   almost_empty          count <= ae_thresh
//   count                 occupancy, 0..DEPTH
// Optional: define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned Depth    = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CntWidth = fifo_cnt_width(ADDR_WIDTH);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;
    fifo_status_t          status;
    logic                  wr_acc, rd_acc, mem_we;

    // Flags come from registered state only, never from rd/wr.
    always_comb begin
        status.full         = (count_q == DepthCnt);
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= af_thresh);
        status.almost_empty = (count_q <= ae_thresh);
    end

    // A full FIFO still takes a write when the same edge pops the head.
    assign wr_acc = wr & (~status.full | rd);
    assign rd_acc = rd & ~status.empty;
    assign mem_we = wr_acc & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (w_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (r_data)
    );

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; flush beats a same-cycle set.
    always_comb begin
        overflow_d  = overflow_q | (wr & status.full & ~rd);
        underflow_d = underflow_q | (rd & status.empty & ~wr);
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Scoreboard bench for fifo_sync_flags (DATA_WIDTH=8, ADDR_WIDTH=3).
// The driver applies one request per cycle, updates a queue-based reference
// model and pushes the expected post-edge state; a monitor pops and compares
// shortly after every rising edge.
module tb_fifo_sync_flags;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n, wr, rd, flush;
    logic [7:0] w_data, r_data;
    logic [3:0] af_thresh, ae_thresh, count;
    logic       full, empty, almost_full, almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif

    always #5 clk = ~clk;

    fifo_sync_flags #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .flush        (flush),
        .w_data       (w_data),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    typedef struct {
        int         cnt;
        bit         full, empty, af, ae;
        bit         has_head;
        logic [7:0] head;
        bit         ovf, udf;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] mq[$];
    bit         m_ovf, m_udf;
    int         total, bad;
    logic [3:0] af_next, ae_next;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endfunction

    // Reference model: a plain queue, updated by the FIFO's acceptance rules.
    task automatic step(input bit w, input bit r, input bit f, input logic [7:0] d);
        exp_t e;
        int   sz;
        @(negedge clk);
        wr = w; rd = r; flush = f; w_data = d;
        af_thresh = af_next; ae_thresh = ae_next;
        @(posedge clk);
        sz = mq.size();
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && sz == DEPTH && !r) m_ovf = 1'b1;
            if (r && sz == 0 && !w) m_udf = 1'b1;
            if (r && sz > 0) void'(mq.pop_front());
            if (w && (sz < DEPTH || r)) mq.push_back(d);
        end
        sz         = mq.size();
        e.cnt      = sz;
        e.full     = (sz == DEPTH);
        e.empty    = (sz == 0);
        e.af       = (sz >= int'(af_thresh));
        e.ae       = (sz <= int'(ae_thresh));
        e.has_head = (sz > 0);
        e.head     = (sz > 0) ? mq[0] : 8'h00;
        e.ovf      = m_ovf;
        e.udf      = m_udf;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("count", {28'b0, count}, mon_e.cnt);
                chk("full", {31'b0, full}, {31'b0, mon_e.full});
                chk("empty", {31'b0, empty}, {31'b0, mon_e.empty});
                chk("almost_full", {31'b0, almost_full}, {31'b0, mon_e.af});
                chk("almost_empty", {31'b0, almost_empty}, {31'b0, mon_e.ae});
                if (mon_e.has_head) chk("r_data", {24'b0, r_data}, {24'b0, mon_e.head});
`ifdef FIFO_ERR_FLAGS_EN
                chk("overflow", {31'b0, overflow}, {31'b0, mon_e.ovf});
                chk("underflow", {31'b0, underflow}, {31'b0, mon_e.udf});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, {28'b0, count}, 0);
        chk({tag, "_empty"}, {31'b0, empty}, 1);
        chk({tag, "_full"}, {31'b0, full}, 0);
        chk({tag, "_almost_empty"}, {31'b0, almost_empty}, 1);
        chk({tag, "_almost_full"}, {31'b0, almost_full}, {31'b0, (af_thresh == 4'd0)});
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, "_overflow"}, {31'b0, overflow}, 0);
        chk({tag, "_underflow"}, {31'b0, underflow}, 0);
`endif
    endtask

    initial begin
        total = 0; bad = 0;
        m_ovf = 1'b0; m_udf = 1'b0;
        reset_n = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0; w_data = 8'h00;
        af_next = 4'd6; ae_next = 4'd1;
        af_thresh = af_next; ae_thresh = ae_next;
        repeat (2) @(negedge clk);
        chk_reset_state("in_reset");
        reset_n = 1'b1;

        // Idle, fill to full, then an overflowing write.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        step(1'b1, 1'b0, 1'b0, 8'h09);
        // Full with simultaneous rd+wr, then drain across the pointer wrap.
        step(1'b1, 1'b1, 1'b0, 8'h09);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        // Underflowing read, then rd+wr on empty.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        // Only head left: rd+wr makes the new word the head.
        step(1'b1, 1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 1'b0, 8'h44);
        step(1'b1, 1'b0, 1'b0, 8'h55);
        // Flush with a concurrent write, then a fresh write.
        step(1'b1, 1'b0, 1'b1, 8'hAA);
        step(1'b1, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));

        // Asynchronous reset between edges at count=4.
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; flush = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_reset_state("async_rst");
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        #1 reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomised traffic with varying thresholds (including > DEPTH).
        for (int blk = 0; blk < 10; blk++) begin
            int wbias;
            af_next = 4'($urandom_range(0, 15));
            ae_next = 4'($urandom_range(0, 15));
            wbias   = $urandom_range(20, 80);
            for (int i = 0; i < 60; i++) begin
                step(($urandom % 100) < wbias, ($urandom % 100) < (100 - wbias),
                     ($urandom % 50) == 0, 8'($urandom));
            end
        end

        step(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
